// File: rtl/ng_cpr_regs_pkg.sv
// rtl/ng_cpr_regs_pkg.sv - control-pulse indices, reset constants and pulse decode for the central register file
//
// Purpose : shared constants for ng_cpr_regs. The write-pulse indices sit alongside
//           the read-pulse indices of the control-pulse vector. All pulses are
//           active-low: a bit at 0 means the pulse is asserted.
// Contents: CP_W, CPX_* indices, Z_RST_DEFAULT, wr_sel_t, decode_cp().
package ng_cpr_regs_pkg;

  localparam int CP_W = 101;

  // Write-pulse indices into the control-pulse vector
  localparam int CPX_WA     = 40;
  localparam int CPX_WQ     = 41;
  localparam int CPX_WZ     = 42;
  localparam int CPX_WLP    = 43;
  localparam int CPX_WALP   = 44;
  localparam int CPX_WA0    = 45;
  localparam int CPX_WA1    = 46;
  localparam int CPX_WA2    = 47;
  localparam int CPX_WA3    = 48;
  localparam int CPX_CLROVF = 49;

  // Start address loaded into Z on reset
  localparam logic [15:0] Z_RST_DEFAULT = 16'o002030;

  // Decoded, active-high write selects
  typedef struct packed {
    logic wr_a;    // WA or WA0
    logic wr_q;    // WQ or WA1
    logic wr_z;    // WZ or WA2
    logic wr_lp;   // WLP or WA3
    logic wr_alp;  // WALP
    logic clr_ovf; // CLROVF
  } wr_sel_t;

  function automatic wr_sel_t decode_cp(input logic [CP_W-1:0] cp);
    wr_sel_t s;
    s.wr_a    = ~cp[CPX_WA]  | ~cp[CPX_WA0];
    s.wr_q    = ~cp[CPX_WQ]  | ~cp[CPX_WA1];
    s.wr_z    = ~cp[CPX_WZ]  | ~cp[CPX_WA2];
    s.wr_lp   = ~cp[CPX_WLP] | ~cp[CPX_WA3];
    s.wr_alp  = ~cp[CPX_WALP];
    s.clr_ovf = ~cp[CPX_CLROVF];
    return s;
  endfunction

endpackage

// File: rtl/ng_cpr_regs_shift_lp.sv
// rtl/ng_cpr_regs_shift_lp.sv - combinational WLP/WALP shift network for the A and LP registers
//
// Purpose : produces the three shifted candidate values; the top level picks one.
// Ports   : write_bus_i  arbitrated write bus
//           lp_i         current LP register
//           a_walp_o     A value for WALP (arithmetic right shift, both sign bits kept)
//           lp_walp_o    LP value for WALP (bit shifted out of A enters LP bit WIDTH-2)
//           lp_wlp_o     LP value for WLP/WA3
module ng_shift_lp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] write_bus_i,
  input  logic [WIDTH-1:0] lp_i,
  output logic [WIDTH-1:0] a_walp_o,
  output logic [WIDTH-1:0] lp_walp_o,
  output logic [WIDTH-1:0] lp_wlp_o
);

  // LP bit 0 is discarded by the WALP shift
  logic unused_lp0;
  assign unused_lp0 = lp_i[0];

  assign a_walp_o  = {write_bus_i[WIDTH-1], write_bus_i[WIDTH-1], write_bus_i[WIDTH-2:1]};
  // LP keeps its top sign bit; the bit shifted out of A lands just below it
  assign lp_walp_o = {lp_i[WIDTH-1], write_bus_i[0], lp_i[WIDTH-2:1]};
  assign lp_wlp_o  = {write_bus_i[0], write_bus_i[0], write_bus_i[WIDTH-1:2]};

endmodule

// File: rtl/ng_cpr_regs.sv
// rtl/ng_cpr_regs.sv - central A/Q/Z/LP register file with overflow and zero/negative status
//
// Purpose : latches the arbitrated write bus on active-low write pulses (one clock
//           latency), applies the WALP/WLP shift rules and tracks sticky overflow.
// Ports   : CLK1          clock, rising edge
//           RESET         synchronous active-high reset (overrides all pulses)
//           CP            active-low control pulse vector
//           WRITE_BUS     arbitrated write bus
//           AREG_RD_BUS, QREG_RD_BUS, ZREG_RD_BUS, LPREG_RD_BUS  register contents
//           A_OVF, A_OVF_STKY, A_NEG, A_ZERO                     A status
module ng_cpr_regs
  import ng_cpr_regs_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] Z_RST = WIDTH'(Z_RST_DEFAULT)
) (
  input  logic             CLK1,
  input  logic             RESET,
  input  logic [CP_W-1:0]  CP,
  input  logic [WIDTH-1:0] WRITE_BUS,
  output logic [WIDTH-1:0] AREG_RD_BUS,
  output logic [WIDTH-1:0] QREG_RD_BUS,
  output logic [WIDTH-1:0] ZREG_RD_BUS,
  output logic [WIDTH-1:0] LPREG_RD_BUS,
  output logic             A_OVF,
  output logic             A_OVF_STKY,
  output logic             A_NEG,
  output logic             A_ZERO
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] lp_q, lp_d;
  logic             stky_q, stky_d;

  logic [WIDTH-1:0] a_walp, lp_walp, lp_wlp;
  wr_sel_t          sel;

  // Only the write pulses matter here; the rest of CP drives other blocks
  logic unused_cp;
  assign unused_cp = ^CP;

  assign sel = decode_cp(CP);

  ng_shift_lp #(.WIDTH(WIDTH)) u_shift_lp (
    .write_bus_i (WRITE_BUS),
    .lp_i        (lp_q),
    .a_walp_o    (a_walp),
    .lp_walp_o   (lp_walp),
    .lp_wlp_o    (lp_wlp)
  );

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    z_d    = z_q;
    lp_d   = lp_q;
    stky_d = stky_q;

    // WALP takes priority over a plain A write
    if (sel.wr_alp) begin
      a_d = a_walp;
    end else if (sel.wr_a) begin
      a_d = WRITE_BUS;
    end

    if (sel.wr_q) begin
      q_d = WRITE_BUS;
    end

    if (sel.wr_z) begin
      z_d = WRITE_BUS;
    end

    if (sel.wr_alp) begin
      lp_d = lp_walp;
    end else if (sel.wr_lp) begin
      lp_d = lp_wlp;
    end

    // Overflow detection looks at the value being written, so set beats clear
    if ((sel.wr_alp || sel.wr_a) && (a_d[WIDTH-1] != a_d[WIDTH-2])) begin
      stky_d = 1'b1;
    end else if (sel.clr_ovf) begin
      stky_d = 1'b0;
    end
  end

  always_ff @(posedge CLK1) begin
    if (RESET) begin
      a_q    <= '0;
      q_q    <= '0;
      z_q    <= Z_RST;
      lp_q   <= '0;
      stky_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      z_q    <= z_d;
      lp_q   <= lp_d;
      stky_q <= stky_d;
    end
  end

  assign AREG_RD_BUS  = a_q;
  assign QREG_RD_BUS  = q_q;
  assign ZREG_RD_BUS  = z_q;
  assign LPREG_RD_BUS = lp_q;
  assign A_OVF_STKY   = stky_q;

  // Status comes from the registered A only; ones-complement has two zeros
  assign A_OVF  = a_q[WIDTH-1] ^ a_q[WIDTH-2];
  assign A_NEG  = a_q[WIDTH-1];
  assign A_ZERO = (a_q == '0) || (a_q == '1);

endmodule

// File: tb/tb_ng_cpr_regs.sv
// tb/tb_ng_cpr_regs.sv - self-checking bench for ng_cpr_regs
module tb_ng_cpr_regs;
  import ng_cpr_regs_pkg::*;

  localparam logic [CP_W-1:0] CP_IDLE = '1;

  logic            CLK1 = 1'b0;
  logic            RESET;
  logic [CP_W-1:0] CP;
  logic [15:0]     WRITE_BUS;
  logic [15:0]     AREG_RD_BUS, QREG_RD_BUS, ZREG_RD_BUS, LPREG_RD_BUS;
  logic            A_OVF, A_OVF_STKY, A_NEG, A_ZERO;

  ng_cpr_regs dut (
    .CLK1         (CLK1),
    .RESET        (RESET),
    .CP           (CP),
    .WRITE_BUS    (WRITE_BUS),
    .AREG_RD_BUS  (AREG_RD_BUS),
    .QREG_RD_BUS  (QREG_RD_BUS),
    .ZREG_RD_BUS  (ZREG_RD_BUS),
    .LPREG_RD_BUS (LPREG_RD_BUS),
    .A_OVF        (A_OVF),
    .A_OVF_STKY   (A_OVF_STKY),
    .A_NEG        (A_NEG),
    .A_ZERO       (A_ZERO)
  );

  always #5 CLK1 = ~CLK1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %o expected %o", tag, obs, exp);
    end
  endtask

  // Scoreboard entries: which output, what it should read after the edge
  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  function automatic logic [15:0] dut_val(input int sel);
    case (sel)
      0: return AREG_RD_BUS;
      1: return QREG_RD_BUS;
      2: return ZREG_RD_BUS;
      3: return LPREG_RD_BUS;
      4: return {15'd0, A_OVF};
      5: return {15'd0, A_OVF_STKY};
      6: return {15'd0, A_NEG};
      default: return {15'd0, A_ZERO};
    endcase
  endfunction

  // Reference model state
  logic [15:0] m_a = 16'hxxxx, m_q, m_z, m_lp;
  logic        m_stky;

  task automatic step(input logic rst, input logic [CP_W-1:0] cp, input logic [15:0] w);
    logic        walp, wa, wq, wz, wlp, clr, set;
    logic [15:0] na, nlp;
    RESET = rst;
    CP = cp;
    WRITE_BUS = w;
    walp = !cp[CPX_WALP];
    wa   = !cp[CPX_WA] || !cp[CPX_WA0];
    wq   = !cp[CPX_WQ] || !cp[CPX_WA1];
    wz   = !cp[CPX_WZ] || !cp[CPX_WA2];
    wlp  = !cp[CPX_WLP] || !cp[CPX_WA3];
    clr  = !cp[CPX_CLROVF];
    if (rst) begin
      m_a = 16'o0; m_q = 16'o0; m_z = 16'o002030; m_lp = 16'o0; m_stky = 1'b0;
    end else begin
      na = walp ? {w[15], w[15], w[14:1]} : (wa ? w : m_a);
      nlp = walp ? {m_lp[15], w[0], m_lp[14:1]} : (wlp ? {w[0], w[0], w[15:2]} : m_lp);
      set = (walp || wa) && (na[15] != na[14]);
      if (set) m_stky = 1'b1;
      else if (clr) m_stky = 1'b0;
      m_a = na;
      m_lp = nlp;
      if (wq) m_q = w;
      if (wz) m_z = w;
    end
    sb.push_back('{"a", 0, m_a});
    sb.push_back('{"q", 1, m_q});
    sb.push_back('{"z", 2, m_z});
    sb.push_back('{"lp", 3, m_lp});
    sb.push_back('{"ovf", 4, {15'd0, m_a[15] ^ m_a[14]}});
    sb.push_back('{"stky", 5, {15'd0, m_stky}});
    sb.push_back('{"neg", 6, {15'd0, m_a[15]}});
    sb.push_back('{"zero", 7, {15'd0, (m_a == 16'o0) || (m_a == 16'o177777)}});
    @(posedge CLK1);
    @(negedge CLK1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, dut_val(e.sel), e.val);
    end
  endtask

  function automatic logic [CP_W-1:0] pulse(input int idx);
    logic [CP_W-1:0] c;
    c = CP_IDLE;
    c[idx] = 1'b0;
    return c;
  endfunction

  initial begin
    logic [CP_W-1:0] c;
    int widx[10];
    widx = '{CPX_WA, CPX_WQ, CPX_WZ, CPX_WLP, CPX_WALP,
             CPX_WA0, CPX_WA1, CPX_WA2, CPX_WA3, CPX_CLROVF};
    RESET = 1'b1;
    CP = CP_IDLE;
    WRITE_BUS = '0;
    @(negedge CLK1);

    // 1. reset, with WA asserted in the same cycle
    step(1'b1, pulse(CPX_WA), 16'o123456);
    chk("rst_a", AREG_RD_BUS, 16'o0);
    chk("rst_z", ZREG_RD_BUS, 16'o002030);
    chk("rst_zero", {15'd0, A_ZERO}, 16'd1);
    chk("rst_stky", {15'd0, A_OVF_STKY}, 16'd0);

    // 2. overflow set, sticky hold, clear
    step(1'b0, pulse(CPX_WA), 16'o040001);
    chk("t2_a", AREG_RD_BUS, 16'o040001);
    chk("t2_ovf", {15'd0, A_OVF}, 16'd1);
    chk("t2_stky", {15'd0, A_OVF_STKY}, 16'd1);
    step(1'b0, pulse(CPX_WA), 16'o000005);
    chk("t2_ovf0", {15'd0, A_OVF}, 16'd0);
    chk("t2_stky_hold", {15'd0, A_OVF_STKY}, 16'd1);
    step(1'b0, pulse(CPX_CLROVF), 16'o0);
    chk("t2_stky_clr", {15'd0, A_OVF_STKY}, 16'd0);
    // set and clear together: set wins
    c = pulse(CPX_WA0);
    c[CPX_CLROVF] = 1'b0;
    step(1'b0, c, 16'o100000);
    chk("t2_set_wins", {15'd0, A_OVF_STKY}, 16'd1);
    step(1'b0, pulse(CPX_CLROVF), 16'o0);
    step(1'b1, CP_IDLE, 16'o0);

    // 3. WALP with LP=0
    step(1'b0, pulse(CPX_WALP), 16'o100003);
    chk("t3_a", AREG_RD_BUS, 16'o140001);
    chk("t3_lp", LPREG_RD_BUS, 16'o040000);

    // 4. WLP
    step(1'b0, pulse(CPX_WLP), 16'o000005);
    chk("t4_lp", LPREG_RD_BUS, 16'o140001);

    // 5. WA+WALP (WALP wins), then WQ+WZ together
    c = pulse(CPX_WA);
    c[CPX_WALP] = 1'b0;
    step(1'b0, c, 16'o000004);
    chk("t5_a", AREG_RD_BUS, 16'o000002);
    c = pulse(CPX_WQ);
    c[CPX_WZ] = 1'b0;
    step(1'b0, c, 16'o012345);
    chk("t5_q", QREG_RD_BUS, 16'o012345);
    chk("t5_z", ZREG_RD_BUS, 16'o012345);

    // 6. minus zero, WA2, mid-run reset
    step(1'b0, pulse(CPX_WA), 16'o177777);
    chk("t6_zero", {15'd0, A_ZERO}, 16'd1);
    chk("t6_neg", {15'd0, A_NEG}, 16'd1);
    step(1'b0, pulse(CPX_WA2), 16'o004000);
    chk("t6_z", ZREG_RD_BUS, 16'o004000);
    c = pulse(CPX_WZ);
    c[CPX_WA3] = 1'b0;
    step(1'b1, c, 16'o070707);
    chk("t6_rst_z", ZREG_RD_BUS, 16'o002030);

    // Unlisted pulse bits alone change nothing
    step(1'b0, pulse(3), 16'o177777);
    step(1'b0, pulse(99), 16'o055555);

    // Random pulse mixes against the model
    for (int i = 0; i < 200; i++) begin
      c = CP_IDLE;
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 3) == 0) c[widx[k]] = 1'b0;
      end
      step($urandom_range(0, 39) == 0, c, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ng_cpr_regs.md
Name: ng_cpr_regs

Overview:
- Central register file holding A, Q, Z and LP, the sources of the A, Q, Z and LP read buses.
- Latches the arbitrated write bus on write control pulses, applying the LP/ALP shift rules.
- Flags A-register overflow and zero/negative status for the branch and sequence logic.
- Clocked on CLK1, so bus data from the current control step is committed at the step's clock edge.

Parameters:
WIDTH, 16, word width including the two sign bits (bits 15 and 14).
Z_RST, 16'o002030, Z value loaded on reset; this is the start address.

Ports:
CLK1  in  1  clock; all state updates on the rising edge.
RESET  in  1  synchronous, active-high reset.
CP  in  101  control pulse vector, decoded through the shared control-pulse index macros.
WRITE_BUS  in  WIDTH  arbitrated write bus from the priority mux.
AREG_RD_BUS  out  WIDTH  A register contents.
QREG_RD_BUS  out  WIDTH  Q register contents.
ZREG_RD_BUS  out  WIDTH  Z register contents.
LPREG_RD_BUS  out  WIDTH  LP register contents.
A_OVF  out  1  A[15] != A[14] (combinational from the A register).
A_OVF_STKY  out  1  sticky overflow flag.
A_NEG  out  1  A[15].
A_ZERO  out  1  A equals +0 (16'o000000) or -0 (16'o177777).

Behaviour:
- Reset (RESET=1 at the clock edge):
  - A=0, Q=0, LP=0, Z=Z_RST, A_OVF_STKY=0.
  - Reset overrides every pulse in the same cycle, including a reset asserted mid-sequence.
- Decoded pulses are active-low, the same convention as the read pulses.
  - Write pulses: WA, WQ, WZ, WLP, WALP.
  - Write-address pulses: WA0, WA1, WA2, WA3.
  - Sticky clear: CLROVF.
  - A write happens when the pulse is 0 at the clock edge. Latency is 1 clock: the new value appears on the *_RD_BUS outputs after that edge.
- A register:
  - WA or WA0 active: A <= WRITE_BUS.
  - WALP active: A <= {W[15], W[15], W[14:1]}, an arithmetic right shift that keeps both sign bits.
  - Priority: WALP over WA/WA0.
- Q register: WQ or WA1 active: Q <= WRITE_BUS.
- Z register: WZ or WA2 active: Z <= WRITE_BUS. Z is never incremented here; the increment is done in the ALU path.
- LP register:
  - WLP or WA3 active: LP <= {W[0], W[0], W[15:2]}.
  - WALP active: LP <= {LP[15], W[0], LP[14:1]}. The shifted-out A bit enters LP bit 14 and LP shifts right.
  - Priority: WALP over WLP/WA3.
- Simultaneous writes to different registers all take effect in the same cycle.
- Sticky overflow:
  - Set on any edge where the newly written A value has bit15 != bit14.
  - Cleared by CLROVF. If set and clear occur in the same cycle, set wins.
  - Cleared only by CLROVF or RESET.
- A_ZERO, A_NEG and A_OVF are combinational from the A register only; they do not look at the next value.
- No read-side gating. Outputs always show register contents; selection is done by the downstream mux.
- Unknown pulse combinations (any pulse field not listed above) leave all registers unchanged.

Decomposition:
- Shared header (ControlPulses.h): CPX indices for WA, WQ, WZ, WLP, WALP, WA0–WA3 and CLROVF, added next to the existing read-pulse indices.
- Z_RST default belongs in the shared constants.
- One sub-module is natural: ng_shift_lp, the combinational WLP/WALP shift network for A and LP. All registers stay in the top level.

Test Plan:
1. Reset: RESET=1 for one edge -> A=Q=LP=0, Z=16'o002030, A_ZERO=1, A_OVF_STKY=0; with WA active in the same cycle, A stays 0.
2. WA with W=16'o040001 -> next cycle A=16'o040001, A_OVF=1, A_OVF_STKY=1. Then WA with W=16'o000005 -> A_OVF=0, A_OVF_STKY stays 1. Then CLROVF -> A_OVF_STKY=0.
3. WALP with W=16'o100003, LP=0 -> A=16'o140001, LP=16'o040000.
4. WLP with W=16'o000005 -> LP=16'o140001.
5. WA and WALP together with W=16'o000004 -> A=16'o000002 (WALP wins). WQ and WZ in the same cycle with W=16'o012345 -> Q=Z=16'o012345.
6. WA with W=16'o177777 -> A_ZERO=1, A_NEG=1. WA2 with W=16'o004000 -> Z=16'o004000. RESET mid-run -> Z returns to 16'o002030.
